// File: rtl/hello_scroll_sequencer.sv
// hello_scroll_sequencer
// Steps through the "HELLO   " message table and feeds one 3-bit symbol per
// scroll step into the 8-stage digit shift chain behind HEX0..HEX7.
// Includes run/hold, a speed select, a pause after each full pass, and a
// fast 8-cycle blanking flush.
module hello_scroll_sequencer #(
  parameter int unsigned DIV         = 25_000_000,
  parameter int unsigned PAUSE_STEPS = 4
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       run,
  input  logic [1:0] speed,
  input  logic       clear,
  output logic       shift_en,
  output logic [2:0] code,
  output logic [2:0] idx,
  output logic       busy
);

  localparam int CW = $clog2(DIV + 1);
  localparam int PW = $clog2(PAUSE_STEPS + 1);
  localparam logic [CW-1:0] DIV_W     = CW'(DIV);
  localparam logic [PW-1:0] PAUSE_END = PW'(PAUSE_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    PAUSE  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic [3:0]    fcnt;
  logic [CW-1:0] limit;
  logic          tick;

  // Message table: H E L L O followed by three blanks.
  function automatic logic [2:0] msg_code(input logic [2:0] pos);
    logic [2:0] c;
    case (pos)
      3'd0:    c = 3'd0;
      3'd1:    c = 3'd1;
      3'd2:    c = 3'd2;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      default: c = 3'd7;
    endcase
    return c;
  endfunction

  // Step period comparison; >= makes a mid-count speed-up tick at once.
  always_comb begin
    limit = DIV_W >> speed;
    tick  = (cnt >= (limit - CW'(1)));
  end

  // Sequencer FSM, step timer and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state    <= IDLE;
      cnt      <= '0;
      pcnt     <= '0;
      fcnt     <= 4'd0;
      idx      <= 3'd0;
      shift_en <= 1'b0;
      code     <= 3'd7;
      busy     <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (clear) begin
            state <= FLUSH;
            fcnt  <= 4'd0;
            idx   <= 3'd0;
            busy  <= 1'b1;
          end else if (run) begin
            state <= SCROLL;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        SCROLL: begin
          if (clear) begin
            // Clear wins over a coincident tick: that symbol is dropped.
            state <= FLUSH;
            cnt   <= '0;
            fcnt  <= 4'd0;
            idx   <= 3'd0;
          end else if (!run) begin
            // Hold position so scrolling resumes mid-message.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (tick) begin
            cnt      <= '0;
            shift_en <= 1'b1;
            code     <= msg_code(idx);
            if (idx == 3'd7) begin
              idx   <= 3'd0;
              pcnt  <= '0;
              state <= PAUSE;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PAUSE: begin
          if (clear) begin
            state <= FLUSH;
            cnt   <= '0;
            pcnt  <= '0;
            fcnt  <= 4'd0;
            idx   <= 3'd0;
          end else if (!run) begin
            state <= IDLE;
            cnt   <= '0;
            pcnt  <= '0;
            idx   <= 3'd0;
            busy  <= 1'b0;
          end else if (tick) begin
            cnt <= '0;
            if (pcnt >= PAUSE_END) begin
              pcnt  <= '0;
              idx   <= 3'd0;
              state <= SCROLL;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        FLUSH: begin
          // Eight blank shifts, then one settling cycle before IDLE.
          cnt <= '0;
          idx <= 3'd0;
          if (fcnt == 4'd8) begin
            fcnt  <= 4'd0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            shift_en <= 1'b1;
            code     <= 3'd7;
            fcnt     <= fcnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          pcnt  <= '0;
          fcnt  <= 4'd0;
          idx   <= 3'd0;
          code  <= 3'd7;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hello_scroll_sequencer.sv
// Scoreboard bench for hello_scroll_sequencer: a message-level reference model
// predicts each cycle's outputs and every shifted symbol; a monitor compares.
module tb_hello_scroll_sequencer;

  localparam int DIV = 8;
  localparam int PS  = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SCROLL = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_FLUSH  = 3;

  logic       clk   = 1'b0;
  logic       key   = 1'b0;
  logic       run   = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       clear = 1'b0;
  logic       shift_en;
  logic [2:0] code;
  logic [2:0] idx;
  logic       busy;

  hello_scroll_sequencer #(.DIV(DIV), .PAUSE_STEPS(PS)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .run     (run),
    .speed   (speed),
    .clear   (clear),
    .shift_en(shift_en),
    .code    (code),
    .idx     (idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic       sh;
    logic [2:0] code;
    logic [2:0] idx;
    logic       busy;
  } status_t;

  typedef struct {
    int         stamp;
    logic [2:0] code;
  } shift_t;

  status_t stq[$];
  shift_t  shq[$];

  // Reference model state, in message terms
  string      msg = "HELLO   ";
  int         m_mode;
  int         m_pos;
  int         m_elapsed;
  int         m_pauses;
  int         m_flushed;
  logic [2:0] m_code;

  function automatic logic [2:0] sym(input byte c);
    case (c)
      "H":     return 3'd0;
      "E":     return 3'd1;
      "L":     return 3'd2;
      "O":     return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_pos     = 0;
    m_elapsed = 0;
    m_pauses  = 0;
    m_flushed = 0;
    m_code    = 3'd7;
  endtask

  // Predict what the next rising edge produces for the inputs now applied.
  task automatic model_step();
    logic    sh;
    int      period;
    status_t st;
    shift_t  se;
    sh = 1'b0;
    if (!key) begin
      model_reset();
    end else begin
      period = DIV >> speed;
      case (m_mode)
        M_IDLE: begin
          if (clear) begin
            m_mode = M_FLUSH; m_flushed = 0; m_pos = 0;
          end else if (run) begin
            m_mode = M_SCROLL; m_elapsed = 0;
          end
        end
        M_SCROLL, M_PAUSE: begin
          if (clear) begin
            m_mode = M_FLUSH; m_flushed = 0; m_pos = 0;
          end else if (!run) begin
            if (m_mode == M_PAUSE) m_pos = 0;
            m_mode = M_IDLE;
          end else if (m_elapsed + 1 >= period) begin
            m_elapsed = 0;
            if (m_mode == M_SCROLL) begin
              sh     = 1'b1;
              m_code = sym(msg[m_pos]);
              m_pos  = (m_pos + 1) % 8;
              if (m_pos == 0) begin
                m_mode = M_PAUSE; m_pauses = 0;
              end
            end else begin
              m_pauses++;
              if (m_pauses == PS) m_mode = M_SCROLL;
            end
          end else begin
            m_elapsed++;
          end
        end
        default: begin
          m_pos = 0;
          if (m_flushed == 8) begin
            m_mode = M_IDLE;
          end else begin
            sh = 1'b1; m_code = 3'd7; m_flushed++;
          end
        end
      endcase
    end
    st.stamp = cyc + 1;
    st.sh    = sh;
    st.code  = m_code;
    st.idx   = 3'(m_pos);
    st.busy  = (m_mode != M_IDLE);
    stq.push_back(st);
    if (sh) begin
      se.stamp = cyc + 1;
      se.code  = m_code;
      shq.push_back(se);
    end
  endtask

  task automatic step(input logic k, input logic r, input logic [1:0] s, input logic c);
    @(negedge clk);
    key = k; run = r; speed = s; clear = c;
    model_step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    key = 1'b0;
    #1;
    chk("async_shift_en", shift_en, 0);
    chk("async_code",     code,     7);
    chk("async_idx",      idx,      0);
    chk("async_busy",     busy,     0);
    model_reset();
    stq.delete();
    shq.delete();
  endtask

  // Monitor: compare DUT outputs against scoreboard entries after each edge.
  status_t e;
  shift_t  s;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() > 0) begin
        e = stq.pop_front();
        chk("shift_en", shift_en, e.sh);
        chk("code",     code,     e.code);
        chk("idx",      idx,      e.idx);
        chk("busy",     busy,     e.busy);
        if (shift_en === 1'b1) begin
          if (shq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_shift: got code %0d with no shift expected (cycle %0d)", code, cyc);
          end else begin
            s = shq.pop_front();
            chk("shift_code",  code, s.code);
            chk("shift_cycle", cyc,  s.stamp);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    model_reset();
    // Reset held with run toggling
    for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), 2'd0, 1'b0);
    // Release, stay idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    // Full pass, pause, wrap to code 0
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    // Speed change mid-count
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'd2, 1'b0);
    // Hold and resume mid-message
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    // Clear, with a second clear during the flush
    step(1'b1, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    // Async reset during a flush
    step(1'b1, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    // Randomized run
    begin
      logic       r_run;
      logic [1:0] r_spd;
      r_run = 1'b1;
      r_spd = 2'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(39, 0) == 0) r_run = ~r_run;
        if ($urandom_range(29, 0) == 0) r_spd = 2'($urandom_range(3, 0));
        step(($urandom_range(499, 0) != 0), r_run, r_spd, ($urandom_range(59, 0) == 0));
      end
    end
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
